// File: rtl/l2_miss_responder_if.sv
// Handshake bundle between the L1 miss path, the L2 miss responder and backing memory.
// The slave modport is the responder; the master modport is its environment (L1 + memory).
// Every channel is valid/ready: a transfer happens on a rising clk edge where both valid and
// ready are high; a producer holds valid and its payload stable until that edge, and a
// consumer may raise or drop ready freely.
interface l2_miss_responder_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 256
);
  logic              l1_req_valid;
  logic              l1_req_ready;
  logic [ADDR_W-1:0] l1_req_addr;
  logic              l1_resp_valid;
  logic              l1_resp_ready;
  logic [ADDR_W-1:0] l1_resp_addr;
  logic [LINE_W-1:0] l1_resp_data;
  logic              l1_resp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_data;

  modport slave (
    input  l1_req_valid, l1_req_addr, l1_resp_ready, mem_req_ready, mem_resp_valid, mem_resp_data,
    output l1_req_ready, l1_resp_valid, l1_resp_addr, l1_resp_data, l1_resp_hit,
           mem_req_valid, mem_req_addr
  );

  modport master (
    output l1_req_valid, l1_req_addr, l1_resp_ready, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  l1_req_ready, l1_resp_valid, l1_resp_addr, l1_resp_data, l1_resp_hit,
           mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/l2_miss_responder.sv
// L2 miss responder: one outstanding L1 miss, direct-mapped tag/data lookup, fixed hit
// latency, single-beat memory fill on a miss (no write-back, the L2 is read-only here).
// Optional macro L2_STATS_EN adds saturating hit/miss counters (stat_hits, stat_misses).
// dbg_state exposes the FSM encoding for checkers.
module l2_miss_responder #(
  parameter int ADDR_W  = 16,
  parameter int LINE_W  = 256,
  parameter int SETS    = 64,
  parameter int HIT_LAT = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  l2_miss_responder_if.slave    bus,
  output logic [2:0]            dbg_state
`ifdef L2_STATS_EN
  ,
  output logic [15:0]           stat_hits,
  output logic [15:0]           stat_misses
`endif
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int CNT_W = $clog2(HIT_LAT + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((LINE_W / 8) - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(HIT_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(HIT_LAT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    WAIT_LAT = 3'd2,
    MEM_REQ  = 3'd3,
    MEM_WAIT = 3'd4,
    RESPOND  = 3'd5
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] req_addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LINE_W-1:0] resp_data_q;
  logic              resp_hit_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              lookup_hit;
  logic              accept;
  logic              fill;

  assign req_idx    = req_addr_q[OFF_W +: IDX_W];
  assign req_tag    = req_addr_q[ADDR_W-1 -: TAG_W];
  assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept     = (state_q == IDLE) && bus.l1_req_valid;
  assign fill       = (state_q == MEM_WAIT) && bus.mem_resp_valid;
  assign dbg_state  = state_q;

  // FSM state register; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs; every output is forced low while rst is high.
  always_comb begin
    state_d           = state_q;
    bus.l1_req_ready  = 1'b0;
    bus.l1_resp_valid = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.l1_resp_addr  = req_addr_q;
    bus.l1_resp_data  = resp_data_q;
    bus.l1_resp_hit   = resp_hit_q;
    bus.mem_req_addr  = req_addr_q;
    case (state_q)
      IDLE: begin
        bus.l1_req_ready = 1'b1;
        if (bus.l1_req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        state_d = lookup_hit ? WAIT_LAT : MEM_REQ;
      end
      WAIT_LAT: begin
        // cnt_q holds (cycles since accept - 1); leave so RESPOND lands on accept + HIT_LAT.
        if (cnt_q == CNT_LAST) state_d = RESPOND;
      end
      MEM_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.mem_resp_valid) state_d = RESPOND;
      end
      RESPOND: begin
        bus.l1_resp_valid = 1'b1;
        if (bus.l1_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      bus.l1_req_ready  = 1'b0;
      bus.l1_resp_valid = 1'b0;
      bus.mem_req_valid = 1'b0;
      bus.l1_resp_addr  = '0;
      bus.l1_resp_data  = '0;
      bus.l1_resp_hit   = 1'b0;
      bus.mem_req_addr  = '0;
    end
  end

  // Request capture, saturating latency counter, response line and valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr_q  <= '0;
      cnt_q       <= '0;
      resp_data_q <= '0;
      resp_hit_q  <= 1'b0;
      valid_q     <= '0;
    end else begin
      if (accept) begin
        req_addr_q <= bus.l1_req_addr & ALIGN_MASK;
        cnt_q      <= '0;
      end else if ((state_q == LOOKUP || state_q == WAIT_LAT) && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == LOOKUP && lookup_hit) begin
        resp_data_q <= data_mem[req_idx];
        resp_hit_q  <= 1'b1;
      end
      if (fill) begin
        resp_data_q      <= bus.mem_resp_data;
        resp_hit_q       <= 1'b0;
        valid_q[req_idx] <= 1'b1;
      end
    end
  end

  // Tag/data store is not reset; only the valid bits say whether a set holds a line.
  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= bus.mem_resp_data;
    end
  end

`ifdef L2_STATS_EN
  // One count per lookup outcome, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state_q == LOOKUP) begin
      if (lookup_hit) begin
        if (stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
      end else begin
        if (stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_l2_miss_responder.sv
// Self-checking bench for l2_miss_responder: reference L2 model, expected-response queues,
// one task per scenario. Stats checks are compiled in when L2_STATS_EN is defined.
module tb_l2_miss_responder;
  localparam int ADDR_W  = 16;
  localparam int LINE_W  = 256;
  localparam int HIT_LAT = 40;

  logic clk;
  logic rst;
  logic [2:0] dbg_state;
`ifdef L2_STATS_EN
  logic [15:0] stat_hits;
  logic [15:0] stat_misses;
`endif

  l2_miss_responder_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  l2_miss_responder #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .SETS(64), .HIT_LAT(HIT_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
`ifdef L2_STATS_EN
    ,
    .stat_hits(stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [LINE_W-1:0] exp_data_q[$];
  logic              exp_hit_q[$];

  // reference L2 contents
  logic              m_valid [64];
  logic [4:0]        m_tag   [64];
  logic [LINE_W-1:0] m_data  [64];

  // observations of the last transaction
  logic              o_saw_mem;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_stable;
  int                o_lat;
  logic [ADDR_W-1:0] o_addr;
  logic [LINE_W-1:0] o_data;
  logic              o_hit;
  logic              o_resp_stable;

  logic [ADDR_W-1:0] ea;
  logic [LINE_W-1:0] ed;
  logic              eh;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // driver: full transaction, starting and ending at a negedge
  task automatic run_txn(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] fill_data,
                         input int mem_delay, input int resp_delay);
    int n;
    int t_acc;
    logic [5:0] idx;
    o_saw_mem = 1'b0; o_mem_addr = '0; o_mem_stable = 1'b1; o_lat = -1;
    o_addr = '0; o_data = '0; o_hit = 1'b0; o_resp_stable = 1'b1;
    idx = addr[10:5];
    exp_addr_q.push_back({addr[15:5], 5'b0});
    if (m_valid[idx] && m_tag[idx] == addr[15:11]) begin
      exp_data_q.push_back(m_data[idx]);
      exp_hit_q.push_back(1'b1);
    end else begin
      exp_data_q.push_back(fill_data);
      exp_hit_q.push_back(1'b0);
    end
    checks++;
    n = 0;
    while (bus.l1_req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      errors++; $display("FAIL req_timeout: l1_req_ready=%b, required 1", bus.l1_req_ready);
      return;
    end
    bus.l1_req_valid = 1'b1;
    bus.l1_req_addr  = addr;
    @(negedge clk);
    bus.l1_req_valid = 1'b0;
    t_acc = cycle;
    n = 0;
    while (bus.l1_resp_valid !== 1'b1 && n < 200) begin
      if (bus.mem_req_valid === 1'b1 && !o_saw_mem) begin
        o_saw_mem  = 1'b1;
        o_mem_addr = bus.mem_req_addr;
        for (int i = 0; i < mem_delay; i++) begin
          @(negedge clk);
          if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== o_mem_addr) o_mem_stable = 1'b0;
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = fill_data;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        m_valid[idx] = 1'b1; m_tag[idx] = addr[15:11]; m_data[idx] = fill_data;
      end else begin
        // a stray fill beat while not waiting for memory must be ignored
        if (n == 5) begin bus.mem_resp_valid = 1'b1; bus.mem_resp_data = ~fill_data; end
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        n++;
      end
    end
    if (n >= 200) begin
      errors++; $display("FAIL resp_timeout: l1_resp_valid=%b, required 1", bus.l1_resp_valid);
      return;
    end
    o_lat  = cycle - t_acc;
    o_addr = bus.l1_resp_addr; o_data = bus.l1_resp_data; o_hit = bus.l1_resp_hit;
    for (int i = 0; i < resp_delay; i++) begin
      @(negedge clk);
      if (bus.l1_resp_valid !== 1'b1 || bus.l1_resp_addr !== o_addr || bus.l1_resp_data !== o_data ||
          bus.l1_resp_hit !== o_hit || bus.l1_req_ready !== 1'b0) o_resp_stable = 1'b0;
    end
    bus.l1_resp_ready = 1'b1;
    @(negedge clk);
    bus.l1_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.l1_req_ready !== 1'b0 || bus.l1_resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 ||
        bus.l1_resp_addr !== '0 || bus.l1_resp_data !== '0 || bus.l1_resp_hit !== 1'b0 ||
        bus.mem_req_addr !== '0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: req_ready=%b resp_valid=%b mem_req_valid=%b resp_addr=%h hit=%b mem_addr=%h state=%0d, required all 0",
               bus.l1_req_ready, bus.l1_resp_valid, bus.mem_req_valid, bus.l1_resp_addr, bus.l1_resp_hit,
               bus.mem_req_addr, dbg_state);
    end
`ifdef L2_STATS_EN
    checks++;
    if (stat_hits !== 16'd0 || stat_misses !== 16'd0) begin
      errors++; $display("FAIL reset_stats: hits=%0d misses=%0d, required 0 0", stat_hits, stat_misses);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.l1_req_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready: l1_req_ready=%b, required 1", bus.l1_req_ready);
    end
  endtask

  task automatic test_cold_miss(input logic [LINE_W-1:0] d);
    run_txn(16'h1234, d, 0, 0);
    checks++;
    if (o_saw_mem !== 1'b1 || o_mem_addr !== 16'h1220) begin
      errors++; $display("FAIL cold_mem_req: seen=%b addr=%h, required 1 1220", o_saw_mem, o_mem_addr);
    end
    checks++;
    if (o_lat != 3) begin
      errors++; $display("FAIL cold_latency: %0d cycles, required 3", o_lat);
    end
    checks++;
    ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front(); eh = exp_hit_q.pop_front();
    if (o_addr !== ea || o_data !== ed || o_hit !== eh) begin
      errors++; $display("FAIL cold_resp: addr=%h hit=%b data=%h, required addr=%h hit=%b data=%h",
                         o_addr, o_hit, o_data, ea, eh, ed);
    end
    checks++;
    if (bus.l1_req_ready !== 1'b1) begin
      errors++; $display("FAIL cold_ready_after: l1_req_ready=%b, required 1", bus.l1_req_ready);
    end
  endtask

  task automatic test_hit_latency();
    run_txn(16'h123F, rand_line(), 0, 0);
    checks++;
    if (o_saw_mem !== 1'b0) begin
      errors++; $display("FAIL hit_no_mem_req: mem_req seen=%b, required 0", o_saw_mem);
    end
    checks++;
    if (o_lat != HIT_LAT) begin
      errors++; $display("FAIL hit_latency: %0d cycles, required %0d", o_lat, HIT_LAT);
    end
    checks++;
    ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front(); eh = exp_hit_q.pop_front();
    if (o_addr !== ea || o_data !== ed || o_hit !== eh) begin
      errors++; $display("FAIL hit_resp: addr=%h hit=%b data=%h, required addr=%h hit=%b data=%h",
                         o_addr, o_hit, o_data, ea, eh, ed);
    end
  endtask

  task automatic test_conflict_eviction(input logic [LINE_W-1:0] e, input logic [LINE_W-1:0] f);
    run_txn(16'h1A20, e, 0, 0);
    checks++;
    ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front(); eh = exp_hit_q.pop_front();
    if (o_saw_mem !== 1'b1 || o_mem_addr !== 16'h1A20 || o_addr !== ea || o_data !== ed || o_hit !== eh) begin
      errors++; $display("FAIL conflict_fill: mem=%b/%h addr=%h hit=%b, required mem=1/1a20 addr=%h hit=%b",
                         o_saw_mem, o_mem_addr, o_addr, o_hit, ea, eh);
    end
    run_txn(16'h1220, f, 0, 0);
    checks++;
    ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front(); eh = exp_hit_q.pop_front();
    if (o_saw_mem !== 1'b1 || o_addr !== ea || o_data !== ed || o_hit !== eh) begin
      errors++; $display("FAIL conflict_evicted: mem=%b addr=%h hit=%b data=%h, required mem=1 addr=%h hit=%b data=%h",
                         o_saw_mem, o_addr, o_hit, o_data, ea, eh, ed);
    end
`ifdef L2_STATS_EN
    checks++;
    if (stat_hits !== 16'd1 || stat_misses !== 16'd3) begin
      errors++; $display("FAIL stats_counts: hits=%0d misses=%0d, required 1 3", stat_hits, stat_misses);
    end
`endif
  endtask

  task automatic test_backpressure();
    run_txn(16'h2345, rand_line(), 5, 10);
    checks++;
    if (o_mem_stable !== 1'b1 || o_mem_addr !== 16'h2340) begin
      errors++; $display("FAIL bp_mem_stable: stable=%b addr=%h, required 1 2340", o_mem_stable, o_mem_addr);
    end
    checks++;
    if (o_resp_stable !== 1'b1) begin
      errors++; $display("FAIL bp_resp_stable: stable=%b, required 1", o_resp_stable);
    end
    checks++;
    if (o_lat != 8) begin
      errors++; $display("FAIL bp_latency: %0d cycles, required 8", o_lat);
    end
    checks++;
    ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front(); eh = exp_hit_q.pop_front();
    if (o_addr !== ea || o_data !== ed || o_hit !== eh) begin
      errors++; $display("FAIL bp_resp: addr=%h hit=%b, required addr=%h hit=%b", o_addr, o_hit, ea, eh);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    int md;
    for (int k = 0; k < 10; k++) begin
      a = {($urandom_range(0, 1) == 0) ? 5'h02 : 5'h03, 6'h10 + 6'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
      md = $urandom_range(0, 3);
      run_txn(a, rand_line(), md, $urandom_range(0, 3));
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front(); eh = exp_hit_q.pop_front();
      checks++;
      if (o_addr !== ea || o_data !== ed || o_hit !== eh || o_saw_mem !== !eh ||
          o_lat != (eh ? HIT_LAT : 3 + md)) begin
        errors++; $display("FAIL b2b_resp[%0d]: addr=%h hit=%b mem=%b lat=%0d, required addr=%h hit=%b mem=%b lat=%0d",
                           k, o_addr, o_hit, o_saw_mem, o_lat, ea, eh, !eh, eh ? HIT_LAT : 3 + md);
      end
      checks++;
      if (bus.l1_req_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: l1_req_ready=%b, required 1", k, bus.l1_req_ready);
      end
    end
  endtask

  task automatic test_reset_mem_wait();
    int n;
    logic bad;
    bus.l1_req_valid = 1'b1;
    bus.l1_req_addr  = 16'h0C48;
    @(negedge clk);
    bus.l1_req_valid = 1'b0;
    n = 0;
    while (bus.mem_req_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    checks++;
    if (dbg_state !== 3'd4) begin
      errors++; $display("FAIL rst_reach_mem_wait: state=%0d, required 4", dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = rand_line();
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.l1_resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL rst_no_response: spurious valid=%b, required 0", bad);
    end
    run_txn(16'h0C48, rand_line(), 0, 0);
    ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front(); eh = exp_hit_q.pop_front();
    checks++;
    if (o_saw_mem !== 1'b1 || o_hit !== 1'b0 || o_data !== ed || o_addr !== ea) begin
      errors++; $display("FAIL rst_then_miss: mem=%b hit=%b addr=%h, required mem=1 hit=0 addr=%h",
                         o_saw_mem, o_hit, o_addr, ea);
    end
    run_txn(16'h1220, rand_line(), 0, 0);
    ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front(); eh = exp_hit_q.pop_front();
    checks++;
    if (o_saw_mem !== 1'b1 || o_hit !== 1'b0 || eh !== 1'b0 || o_data !== ed) begin
      errors++; $display("FAIL rst_cleared_valid: mem=%b hit=%b, required mem=1 hit=0", o_saw_mem, o_hit);
    end
  endtask

  initial begin
    logic [LINE_W-1:0] d;
    rst = 1'b1;
    bus.l1_req_valid = 1'b0; bus.l1_req_addr = '0; bus.l1_resp_ready = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    for (int i = 0; i < 64; i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0; end
    @(negedge clk);
    test_reset();
    d = rand_line();
    test_cold_miss(d);
    test_hit_latency();
    test_conflict_eviction(rand_line(), rand_line());
    test_backpressure();
    test_back_to_back();
    test_reset_mem_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
